// File: rtl/traffic_phase_ctrl_if.sv
// Signal bundle between the traffic phase controller and its sensors/lamps.
// Pedestrian signals exist only when PED_WALK_EN is defined.
interface traffic_phase_ctrl_if;
    logic       car_present;
    logic [2:0] light_pros;
    logic [2:0] light_wash;
    logic [2:0] phase;
`ifdef PED_WALK_EN
    logic       ped_req;
    logic       walk;

    modport master (output car_present, ped_req,
                    input  light_pros, light_wash, phase, walk);
    modport slave  (input  car_present, ped_req,
                    output light_pros, light_wash, phase, walk);
`else
    modport master (output car_present,
                    input  light_pros, light_wash, phase);
    modport slave  (input  car_present,
                    output light_pros, light_wash, phase);
`endif
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Two-road actuated traffic phase controller driven by one shared dwell timer.
// Optional pedestrian walk phase is compiled in with the PED_WALK_EN macro.
module traffic_phase_ctrl #(
    parameter int CNT_W       = 8,
    parameter int WASH_MIN    = 4,
    parameter int YLW_CYC     = 1,
    parameter int ALL_RED_CYC = 1,
    parameter int PROS_MIN    = 4,
    parameter int PROS_MAX    = 8
`ifdef PED_WALK_EN
    , parameter int WALK_CYC  = 3
`endif
) (
    input  logic               clk,
    input  logic               rst,
    traffic_phase_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        ST_WASH_GRN = 3'd0,
        ST_WASH_YLW = 3'd1,
        ST_CLR_A    = 3'd2,
        ST_PROS_GRN = 3'd3,
        ST_PROS_YLW = 3'd4,
        ST_CLR_B    = 3'd5,
        ST_WALK     = 3'd6
    } state_t;

    localparam logic [2:0] L_RED = 3'b001;
    localparam logic [2:0] L_YLW = 3'b010;
    localparam logic [2:0] L_GRN = 3'b100;

    // Timer values on the last cycle of each phase.
    localparam logic [CNT_W-1:0] L_WASH_LAST = CNT_W'(WASH_MIN - 1);
    localparam logic [CNT_W-1:0] L_YLW_LAST  = CNT_W'(YLW_CYC - 1);
    localparam logic [CNT_W-1:0] L_CLR_LAST  = CNT_W'((ALL_RED_CYC > 0) ? ALL_RED_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] L_PMIN_LAST = CNT_W'(PROS_MIN - 1);
    localparam logic [CNT_W-1:0] L_PMAX_LAST = CNT_W'(PROS_MAX - 1);
    localparam logic [CNT_W-1:0] L_TMR_SAT   = {CNT_W{1'b1}};
`ifdef PED_WALK_EN
    localparam logic [CNT_W-1:0] L_WALK_LAST = CNT_W'(WALK_CYC - 1);
`endif

    state_t           r_state;
    state_t           w_next;
    state_t           w_after_clr;
    logic [CNT_W-1:0] r_timer;
    logic             r_car_req;
    logic             w_enter_pros;
`ifdef PED_WALK_EN
    logic             r_ped_pend;
    logic             w_enter_walk;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_WASH_GRN;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst || (w_next != r_state)) r_timer <= '0;
        else if (r_timer != L_TMR_SAT)  r_timer <= r_timer + CNT_W'(1);
    end

    assign w_enter_pros = (w_next == ST_PROS_GRN) && (r_state != ST_PROS_GRN);

    // Clearing on entry to Prospect green takes priority over a new request.
    always_ff @(posedge clk) begin
        if (rst)                                                 r_car_req <= 1'b0;
        else if (w_enter_pros)                                   r_car_req <= 1'b0;
        else if (bus.car_present && (r_state != ST_PROS_GRN))    r_car_req <= 1'b1;
    end

`ifdef PED_WALK_EN
    assign w_enter_walk = (w_next == ST_WALK) && (r_state != ST_WALK);

    always_ff @(posedge clk) begin
        if (rst)                                         r_ped_pend <= 1'b0;
        else if (w_enter_walk)                           r_ped_pend <= 1'b0;
        else if (bus.ped_req && (r_state != ST_WALK))    r_ped_pend <= 1'b1;
    end
`endif

    always_comb begin
        w_next         = r_state;
        w_after_clr    = ST_WASH_GRN;
        bus.light_pros = L_RED;
        bus.light_wash = L_RED;
        bus.phase      = r_state;
`ifdef PED_WALK_EN
        bus.walk       = 1'b0;
        if (r_ped_pend) w_after_clr = ST_WALK;
`endif
        case (r_state)
            ST_WASH_GRN: begin
                bus.light_wash = L_GRN;
                if ((r_timer >= L_WASH_LAST) && (r_car_req || bus.car_present))
                    w_next = ST_WASH_YLW;
            end
            ST_WASH_YLW: begin
                bus.light_wash = L_YLW;
                if (r_timer == L_YLW_LAST)
                    w_next = (ALL_RED_CYC == 0) ? ST_PROS_GRN : ST_CLR_A;
            end
            ST_CLR_A: begin
                if (r_timer == L_CLR_LAST) w_next = ST_PROS_GRN;
            end
            ST_PROS_GRN: begin
                bus.light_pros = L_GRN;
                if (((r_timer >= L_PMIN_LAST) && !bus.car_present) || (r_timer == L_PMAX_LAST))
                    w_next = ST_PROS_YLW;
            end
            ST_PROS_YLW: begin
                bus.light_pros = L_YLW;
                if (r_timer == L_YLW_LAST)
                    w_next = (ALL_RED_CYC == 0) ? w_after_clr : ST_CLR_B;
            end
            ST_CLR_B: begin
                if (r_timer == L_CLR_LAST) w_next = w_after_clr;
            end
`ifdef PED_WALK_EN
            ST_WALK: begin
                bus.walk = 1'b1;
                if (r_timer == L_WALK_LAST) w_next = ST_WASH_GRN;
            end
`endif
            default: begin
                w_next = ST_WASH_GRN;
            end
        endcase
    end
endmodule
